// File: rtl/sr_xfer_ctrl_if.sv
// Handshake and data bundle between a register-access front end and the
// shift-register transfer sequencer.
interface sr_xfer_ctrl_if #(
    parameter int Width = 16,
    parameter int LenW  = 5
);
    logic             START;
    logic             ABORT;
    logic [LenW-1:0]  LEN;
    logic [Width-1:0] D;
    logic [Width-1:0] SR_D;
    logic             SR_L;
    logic             SR_CE;
    logic             SCLK;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, ABORT, LEN, D,
        input  SR_D, SR_L, SR_CE, SCLK, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, LEN, D,
        output SR_D, SR_L, SR_CE, SCLK, BUSY, DONE
    );
endinterface

// File: rtl/sr_xfer_ctrl.sv
// Sequencer for a parallel-load shift register: load once, then issue LEN
// shift enables at a divided bit rate with an aligned serial clock.
module sr_xfer_ctrl #(
    parameter int Width = 16,
    parameter int Div   = 4,
    parameter int LenW  = 5
) (
    input  logic           C,
    input  logic           CLR,
    sr_xfer_ctrl_if.slave  bus
);
    localparam int DW = $clog2(Div);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    state_t           state_r, state_s;
    logic [DW-1:0]    dcnt_r, dcnt_s;
    logic [LenW-1:0]  bcnt_r, bcnt_s;
    logic [LenW-1:0]  n_r, n_s;
    logic [LenW-1:0]  eff_len_s;
    logic [Width-1:0] sr_d_r, sr_d_s;
    logic             sr_l_r, sr_ce_r, sclk_r, busy_r, done_r;
    logic             sr_l_s, sr_ce_s, sclk_s, busy_s, done_s;

    // Effective length: zero or oversize requests shift the full register.
    always_comb begin
        if ((bus.LEN == {LenW{1'b0}}) || (bus.LEN > LenW'(Width))) begin
            eff_len_s = LenW'(Width);
        end else begin
            eff_len_s = bus.LEN;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_s = state_r;
        dcnt_s  = dcnt_r;
        bcnt_s  = bcnt_r;
        n_s     = n_r;
        sr_d_s  = sr_d_r;
        case (state_r)
            IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    state_s = LOAD;
                    sr_d_s  = bus.D;
                    n_s     = eff_len_s;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                dcnt_s = {DW{1'b0}};
                bcnt_s = {LenW{1'b0}};
                if (bus.ABORT) begin
                    state_s = IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ABORT) begin
                    state_s = IDLE;
                    dcnt_s  = {DW{1'b0}};
                    bcnt_s  = {LenW{1'b0}};
                end else if (dcnt_r == DW'(Div - 1)) begin
                    dcnt_s = {DW{1'b0}};
                    if (bcnt_r == (n_r - LenW'(1))) begin
                        state_s = FINISH;
                        bcnt_s  = {LenW{1'b0}};
                    end else begin
                        bcnt_s = bcnt_r + LenW'(1);
                    end
                end else begin
                    dcnt_s = dcnt_r + DW'(1);
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                dcnt_s  = {DW{1'b0}};
                bcnt_s  = {LenW{1'b0}};
            end
        endcase
    end

    // Outputs are precomputed from the next state so they leave a flop edge-aligned with it.
    always_comb begin
        sr_l_s  = (state_s == LOAD);
        busy_s  = (state_s != IDLE);
        sr_ce_s = (state_s == SHIFT) && (dcnt_s == DW'(Div - 1));
        sclk_s  = (state_s == SHIFT) && (dcnt_s >= DW'(Div / 2));
        done_s  = (state_s == FINISH);
    end

    // State, counters and output registers.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_r <= IDLE;
            dcnt_r  <= {DW{1'b0}};
            bcnt_r  <= {LenW{1'b0}};
            n_r     <= {LenW{1'b0}};
            sr_d_r  <= {Width{1'b0}};
            sr_l_r  <= 1'b0;
            sr_ce_r <= 1'b0;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            dcnt_r  <= dcnt_s;
            bcnt_r  <= bcnt_s;
            n_r     <= n_s;
            sr_d_r  <= sr_d_s;
            sr_l_r  <= sr_l_s;
            sr_ce_r <= sr_ce_s;
            sclk_r  <= sclk_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.SR_D  = sr_d_r;
    assign bus.SR_L  = sr_l_r;
    assign bus.SR_CE = sr_ce_r;
    assign bus.SCLK  = sclk_r;
    assign bus.BUSY  = busy_r;
    assign bus.DONE  = done_r;
endmodule

// File: tb/tb_sr_xfer_ctrl.sv
// Directed bench for sr_xfer_ctrl: three instances (Div=4, 2, 8) share one
// stimulus; per-cycle expectations are computed from the transfer timing.
module tb_sr_xfer_ctrl;
    logic        clk = 1'b0;
    logic        clr;
    logic        start, abort;
    logic [4:0]  len;
    logic [15:0] d;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    sr_xfer_ctrl_if #(.Width(16), .LenW(5)) if4 ();
    sr_xfer_ctrl_if #(.Width(16), .LenW(5)) if2 ();
    sr_xfer_ctrl_if #(.Width(16), .LenW(5)) if8 ();

    assign if4.START = start; assign if4.ABORT = abort; assign if4.LEN = len; assign if4.D = d;
    assign if2.START = start; assign if2.ABORT = abort; assign if2.LEN = len; assign if2.D = d;
    assign if8.START = start; assign if8.ABORT = abort; assign if8.LEN = len; assign if8.D = d;

    sr_xfer_ctrl #(.Width(16), .Div(4), .LenW(5)) dut4 (.C(clk), .CLR(clr), .bus(if4));
    sr_xfer_ctrl #(.Width(16), .Div(2), .LenW(5)) dut2 (.C(clk), .CLR(clr), .bus(if2));
    sr_xfer_ctrl #(.Width(16), .Div(8), .LenW(5)) dut8 (.C(clk), .CLR(clr), .bus(if8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int div, output logic [15:0] srd, output logic l,
                          output logic ce, output logic sck, output logic bsy, output logic dn);
        case (div)
            2: begin srd = if2.SR_D; l = if2.SR_L; ce = if2.SR_CE; sck = if2.SCLK; bsy = if2.BUSY; dn = if2.DONE; end
            8: begin srd = if8.SR_D; l = if8.SR_L; ce = if8.SR_CE; sck = if8.SCLK; bsy = if8.BUSY; dn = if8.DONE; end
            default: begin srd = if4.SR_D; l = if4.SR_L; ce = if4.SR_CE; sck = if4.SCLK; bsy = if4.BUSY; dn = if4.DONE; end
        endcase
    endtask

    // Called at a negedge; t0 is the following posedge. Checks every cycle up to the first IDLE cycle.
    task automatic xfer_check(input int div, input logic [4:0] len_in, input int n,
                              input logic [15:0] word, input bit hold);
        logic [15:0] srd, model, ser;
        logic        l, ce, sck, bsy, dn;
        bit          in_shift;
        int          dc;
        len = len_in; d = word; start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
        model = 16'h0000; ser = 16'h0000;
        for (int o = 1; o <= n * div + 3; o++) begin
            @(negedge clk);
            sample(div, srd, l, ce, sck, bsy, dn);
            in_shift = (o >= 2) && (o <= 1 + n * div);
            dc = (o - 2) % div;
            chk($sformatf("div%0d len%0d sr_l o=%0d", div, len_in, o), {31'd0, l}, {31'd0, o == 1});
            chk($sformatf("div%0d len%0d sr_ce o=%0d", div, len_in, o), {31'd0, ce}, {31'd0, in_shift && (dc == div - 1)});
            chk($sformatf("div%0d len%0d sclk o=%0d", div, len_in, o), {31'd0, sck}, {31'd0, in_shift && (dc >= div / 2)});
            chk($sformatf("div%0d len%0d busy o=%0d", div, len_in, o), {31'd0, bsy}, {31'd0, o <= 2 + n * div});
            chk($sformatf("div%0d len%0d done o=%0d", div, len_in, o), {31'd0, dn}, {31'd0, o == 2 + n * div});
            if (o == 1) chk($sformatf("div%0d len%0d sr_d", div, len_in), {16'd0, srd}, {16'd0, word});
            if (ce) begin
                ser   = {ser[14:0], model[15]};
                model = model << 1;
            end
            if (l) model = srd;
        end
        chk($sformatf("div%0d len%0d serial", div, len_in), {16'd0, ser}, {16'd0, word >> (16 - n)});
    endtask

    task automatic reset_all();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [15:0] srd;
        logic        l, ce, sck, bsy, dn;
        int          n_ce, n_dn, n_busy;

        clr = 1'b1; start = 1'b0; abort = 1'b0; len = 5'd0; d = 16'h0000;
        repeat (2) @(negedge clk);
        sample(4, srd, l, ce, sck, bsy, dn);
        chk("rst sr_d", {16'd0, srd}, 32'd0);
        chk("rst sr_l", {31'd0, l}, 32'd0);
        chk("rst sr_ce", {31'd0, ce}, 32'd0);
        chk("rst sclk", {31'd0, sck}, 32'd0);
        chk("rst busy", {31'd0, bsy}, 32'd0);
        chk("rst done", {31'd0, dn}, 32'd0);
        clr = 1'b0;

        // Basic transfer and length corner cases
        xfer_check(4, 5'd16, 16, 16'hA5C3, 1'b0);
        xfer_check(4, 5'd1,  1,  16'h8001, 1'b0);
        xfer_check(4, 5'd0,  16, 16'h1E2D, 1'b0);
        xfer_check(4, 5'd20, 16, 16'hC0DE, 1'b0);

        // START held through a transfer, then back-to-back with a new word
        xfer_check(4, 5'd4, 4, 16'h9ABC, 1'b1);
        xfer_check(4, 5'd3, 3, 16'h6000, 1'b0);

        // ABORT sampled at the edge that would open the second SR_CE cycle
        len = 5'd8; d = 16'h3C5A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_ce = 0;
        for (int o = 1; o <= 8; o++) begin
            @(negedge clk);
            sample(4, srd, l, ce, sck, bsy, dn);
            n_ce += int'(ce);
        end
        abort = 1'b1;
        @(negedge clk);
        sample(4, srd, l, ce, sck, bsy, dn);
        chk("abort sr_ce", {31'd0, ce}, 32'd0);
        chk("abort busy", {31'd0, bsy}, 32'd0);
        chk("abort ce count", n_ce, 32'd1);
        abort = 1'b0;
        n_dn = 0; n_busy = 0;
        repeat (20) begin
            @(negedge clk);
            sample(4, srd, l, ce, sck, bsy, dn);
            n_dn += int'(dn); n_busy += int'(bsy);
        end
        chk("abort no done", n_dn, 32'd0);
        chk("abort stays idle", n_busy, 32'd0);
        chk("abort sr_d kept", {16'd0, srd}, {16'd0, 16'h3C5A});

        // START together with ABORT in IDLE is ignored
        start = 1'b1; abort = 1'b1; d = 16'h7777;
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        sample(4, srd, l, ce, sck, bsy, dn);
        chk("start+abort busy", {31'd0, bsy}, 32'd0);
        chk("start+abort sr_l", {31'd0, l}, 32'd0);
        chk("start+abort sr_d", {16'd0, srd}, {16'd0, 16'h3C5A});

        // CLR mid-SHIFT after three shift pulses
        len = 5'd8; d = 16'hBEEF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_ce = 0;
        for (int o = 1; o <= 14; o++) begin
            @(negedge clk);
            sample(4, srd, l, ce, sck, bsy, dn);
            n_ce += int'(ce);
        end
        chk("clr ce before", n_ce, 32'd3);
        #2 clr = 1'b1;
        #1 sample(4, srd, l, ce, sck, bsy, dn);
        chk("clr sr_d", {16'd0, srd}, 32'd0);
        chk("clr sr_l", {31'd0, l}, 32'd0);
        chk("clr sr_ce", {31'd0, ce}, 32'd0);
        chk("clr sclk", {31'd0, sck}, 32'd0);
        chk("clr busy", {31'd0, bsy}, 32'd0);
        chk("clr done", {31'd0, dn}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        n_dn = 0;
        repeat (10) begin
            @(negedge clk);
            sample(4, srd, l, ce, sck, bsy, dn);
            n_dn += int'(dn);
        end
        chk("clr no done", n_dn, 32'd0);
        xfer_check(4, 5'd5, 5, 16'h4321, 1'b0);

        // SCLK shape for the other dividers, each started right after CLR release
        reset_all();
        xfer_check(2, 5'd3, 3, 16'hE000, 1'b0);
        reset_all();
        xfer_check(8, 5'd2, 2, 16'h4000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
